sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
Single-clock, parametrised synchronous FIFO that succeeds the dual-port fifo_memory.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain, e.g. as an elastic buffer in front of a UART/SPI transmitter.

Parameters:
FIFO_WIDTH, 16, data word width in bits
FIFO_DEPTH, 512, number of entries; must be a power of two, >= 4
ADDR_SIZE, $clog2(FIFO_DEPTH), pointer index width
ALMOST_FULL_TH, FIFO_DEPTH-2, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value
FWFT, 0, 0 = standard mode (1-cycle read latency); 1 = first-word-fall-through

Ports:
clk  input  1  the single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
din  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (standard mode) / pop (FWFT)
dout  output  FIFO_WIDTH  read data
valid  output  1  dout holds valid read data
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_TH
almost_empty  output  1  count <= ALMOST_EMPTY_TH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected
count  output  ADDR_SIZE+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (asynchronous, rst=1):
  - wr_ptr, rd_ptr, count and dout go to 0.
  - valid, full, almost_full, overflow and underflow go to 0.
  - empty and almost_empty go to 1.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents immediately; the first write after release lands at index 0.
- Pointers are ADDR_SIZE+1 bits; the MSB is a wrap bit. Index = ptr[ADDR_SIZE-1:0]; the pointer wraps naturally from DEPTH-1 to 0.
- count is a registered up/down counter (+1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted). All flags are derived from count, so every flag updates in the same cycle as count.
- Request acceptance is evaluated against flags at the rising edge:
  - wr_ok = wr_en & (~full | rd_ok)
  - rd_ok = rd_en & ~empty
  - When full and both wr_en and rd_en are high, both are accepted and count stays at DEPTH.
  - When empty and both are high, only the write is accepted; the read is rejected.
- overflow = registered (wr_en & ~wr_ok); the rejected data is dropped. underflow = registered (rd_en & ~rd_ok). Each is high for exactly the cycle after the offending edge.
- Standard mode (FWFT=0):
  - An accepted read registers mem[rd_idx] into dout at that edge.
  - valid is high for exactly that following cycle.
  - dout holds its last value when no read occurs.
  - Read latency is 1 clock.
- FWFT mode (FWFT=1):
  - dout = mem[rd_idx] whenever empty=0.
  - valid = ~empty.
  - rd_en acts as pop/acknowledge: the next word appears the cycle after an accepted pop.
  - The first written word appears on dout the cycle after its write edge (write-to-valid latency 1).
- Memory write and read at the same index in the same cycle can only occur when count==0 (read rejected) or count==DEPTH (read returns the old word, write overwrites the freed slot). No read-during-write bypass is required.
- Threshold parameters outside 0..DEPTH are a configuration error; elaboration fails via a generate-time check.

Decomposition:
- Package fifo_pkg:
  - default width/depth constants
  - helper function for threshold validation
  - a typedef for the count/pointer width
- Sub-module fifo_ram: simple dual-port RAM with one write port and one read port.
  - Read port is registered for FWFT=0 and combinational for FWFT=1, selected by parameter.
  - The top level holds the pointers, counter, flags and error logic.

Test Plan:
(DEPTH=8, WIDTH=16, AF_TH=6, AE_TH=2)
- Reset, then idle: empty=1, almost_empty=1, count=0, valid=0, full=0, dout=0.
- FWFT=0: write 0xABCD, 0xDCBA, 0xCBCB on 3 edges, then 3 reads.
  - dout = ABCD, DCBA, CBCB each with valid=1 one cycle after its read edge.
  - count goes 3→0; empty returns to 1.
- Write 8 words (0x0001..0x0008):
  - almost_full rises at count=6; full=1 at count=8.
  - A 9th write of 0xFFFF gives overflow=1 for one cycle, and count stays 8.
  - Draining returns 0x0001..0x0008 with no 0xFFFF.
- Full plus simultaneous wr_en/rd_en with din=0x1234: read returns the oldest word, count stays 8, and 0x1234 is read last after 7 more reads (exercises pointer wrap).
- Empty plus rd_en alone gives underflow=1 for one cycle and count stays 0. Empty plus wr_en & rd_en together: the write is accepted, underflow=1, and count becomes 1.
- FWFT=1:
  - Write 0x5A5A; next cycle valid=1 and dout=0x5A5A without rd_en.
  - Pop gives valid=0 and empty=1.
  - Assert rst with count=5: count=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and configuration helpers for the sync_fifo_flags FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 512;
  localparam int unsigned DEF_ADDR  = $clog2(DEF_DEPTH);

  // Occupancy/pointer type at the default depth: one extra bit for the wrap flag.
  typedef logic [DEF_ADDR:0] ptr_t;

  function automatic bit th_ok(input int th, input int depth);
    return (th >= 0) && (th <= depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one read port that is registered or combinational.
module fifo_ram #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          REG_READ = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;

      // Read samples the pre-write word, so a full-FIFO read/write at one index returns the old data.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
      end

      assign rdata_o = rdata_q;
    end else begin : g_comb_read
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, re_i, rst_i};
      assign rdata_o     = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, error pulses and optional FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH      = DEF_DEPTH,
  parameter int ADDR_SIZE       = $clog2(FIFO_DEPTH),
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter bit FWFT            = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_SIZE:0]    count
);

  generate
    if (!th_ok(ALMOST_FULL_TH, FIFO_DEPTH) || !th_ok(ALMOST_EMPTY_TH, FIFO_DEPTH)) begin : g_bad_th
      $error("sync_fifo_flags: almost-full/almost-empty threshold outside 0..FIFO_DEPTH");
    end
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("sync_fifo_flags: FIFO_DEPTH must be a power of two and at least 4");
    end
  endgenerate

  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(ALMOST_EMPTY_TH);

  logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic               valid_q, overflow_q, underflow_q;
  logic               wr_ok, rd_ok;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= rd_ok;
      overflow_q  <= wr_en & ~wr_ok;
      underflow_q <= rd_en & ~rd_ok;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .WIDTH    (FIFO_WIDTH),
    .DEPTH    (FIFO_DEPTH),
    .AW       (ADDR_SIZE),
    .REG_READ (!FWFT)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[ADDR_SIZE-1:0]),
    .wdata_i (din),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[ADDR_SIZE-1:0]),
    .rdata_o (ram_rdata)
  );

  // FWFT presents the head word directly; force zero when empty so dout is defined after reset.
  assign dout  = (FWFT && empty) ? '0 : ram_rdata;
  assign valid = FWFT ? ~empty : valid_q;

endmodule
